// File: rtl/ship_placement_ctrl.sv
// Cursor-driven ship placement for the COLOCATION phase; raises finished_placing once all ships are set.
// Define PLACE_WRAP_EN to make the cursor wrap at grid borders instead of saturating.
module ship_placement_ctrl #(
  parameter int GRID_W    = 5,
  parameter int GRID_H    = 5,
  parameter int MAX_SHIPS = 5,
  parameter int XW        = $clog2(GRID_W),
  parameter int YW        = $clog2(GRID_H)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [2:0]                 ships_count,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_left,
  input  logic                       btn_right,
  input  logic                       btn_confirm,
  output logic [XW-1:0]              cursor_x,
  output logic [YW-1:0]              cursor_y,
  output logic [GRID_W*GRID_H-1:0]   occupancy,
  output logic [2:0]                 ships_remaining,
  output logic                       place_ok,
  output logic                       place_err,
  output logic                       finished_placing,
  output logic [1:0]                 fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] MOVE = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CELLS = GRID_W * GRID_H;
  localparam int IW    = $clog2(CELLS);
  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

  logic [1:0]    state;
  logic [4:0]    btn_q;
  logic [4:0]    btn_now;
  logic [4:0]    btn_edge;
  logic          up_e, down_e, left_e, right_e, confirm_e;
  logic [2:0]    ships_clamped;
  logic [XW-1:0] next_x;
  logic [YW-1:0] next_y;
  logic [IW-1:0] cell_idx;

  assign btn_now  = {btn_up, btn_down, btn_left, btn_right, btn_confirm};
  assign btn_edge = btn_now & ~btn_q;
  assign {up_e, down_e, left_e, right_e, confirm_e} = btn_edge;

  assign cell_idx         = IW'(cursor_y) * IW'(GRID_W) + IW'(cursor_x);
  assign finished_placing = (state == DONE);
  assign fsm_state        = state;

  always_comb begin
    ships_clamped = ships_count;
    if (ships_count == 3'd0)
      ships_clamped = 3'd1;
    else if (int'(ships_count) > MAX_SHIPS)
      ships_clamped = 3'(MAX_SHIPS);
  end

  // One move per cycle, priority up > down > left > right.
  always_comb begin
    next_x = cursor_x;
    next_y = cursor_y;
    if (up_e) begin
      if (cursor_y != '0) next_y = cursor_y - YW'(1);
`ifdef PLACE_WRAP_EN
      else next_y = Y_MAX;
`endif
    end else if (down_e) begin
      if (cursor_y != Y_MAX) next_y = cursor_y + YW'(1);
`ifdef PLACE_WRAP_EN
      else next_y = '0;
`endif
    end else if (left_e) begin
      if (cursor_x != '0) next_x = cursor_x - XW'(1);
`ifdef PLACE_WRAP_EN
      else next_x = X_MAX;
`endif
    end else if (right_e) begin
      if (cursor_x != X_MAX) next_x = cursor_x + XW'(1);
`ifdef PLACE_WRAP_EN
      else next_x = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      btn_q           <= '0;
      cursor_x        <= '0;
      cursor_y        <= '0;
      occupancy       <= '0;
      ships_remaining <= '0;
      place_ok        <= 1'b0;
      place_err       <= 1'b0;
    end else begin
      btn_q     <= btn_now;
      place_ok  <= 1'b0;
      place_err <= 1'b0;
      case (state)
        IDLE: if (enable) state <= LOAD;
        LOAD: begin
          occupancy       <= '0;
          cursor_x        <= '0;
          cursor_y        <= '0;
          ships_remaining <= ships_clamped;
          state           <= MOVE;
        end
        MOVE: begin
          // Dropping enable wins over any button pressed in the same cycle.
          if (!enable) begin
            state <= IDLE;
          end else if (confirm_e) begin
            if (!occupancy[cell_idx]) begin
              occupancy[cell_idx] <= 1'b1;
              ships_remaining     <= ships_remaining - 3'd1;
              place_ok            <= 1'b1;
              cursor_x            <= '0;
              cursor_y            <= '0;
              if (ships_remaining == 3'd1) state <= DONE;
            end else begin
              place_err <= 1'b1;
            end
          end else begin
            cursor_x <= next_x;
            cursor_y <= next_y;
          end
        end
        DONE: if (!enable) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ship_placement_ctrl.sv
// Directed bench for ship_placement_ctrl; expectations follow PLACE_WRAP_EN when it is defined.
module tb_ship_placement_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_MOVE = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Button vector order: {up, down, left, right, confirm}
  localparam logic [4:0] B_UP  = 5'b10000;
  localparam logic [4:0] B_DN  = 5'b01000;
  localparam logic [4:0] B_LT  = 5'b00100;
  localparam logic [4:0] B_RT  = 5'b00010;
  localparam logic [4:0] B_CF  = 5'b00001;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [2:0]  ships_count;
  logic        btn_up, btn_down, btn_left, btn_right, btn_confirm;
  logic [2:0]  cursor_x;
  logic [2:0]  cursor_y;
  logic [24:0] occupancy;
  logic [2:0]  ships_remaining;
  logic        place_ok, place_err, finished_placing;
  logic [1:0]  fsm_state;

  int n_chk = 0;
  int n_bad = 0;

  ship_placement_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .ships_count(ships_count),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_confirm(btn_confirm),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .occupancy(occupancy),
    .ships_remaining(ships_remaining), .place_ok(place_ok), .place_err(place_err),
    .finished_placing(finished_placing), .fsm_state(fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [4:0] b);
    {btn_up, btn_down, btn_left, btn_right, btn_confirm} = b;
  endtask

  task automatic press(input logic [4:0] b);
    set_btn(b);
    step();
    set_btn(5'b0);
    step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cursor(input string tag, input int x, input int y);
    chk({tag, "_x"}, 32'(cursor_x), 32'(x));
    chk({tag, "_y"}, 32'(cursor_y), 32'(y));
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; ships_count = 3'd0;
    set_btn(5'b0);
    #3;
    chk("rst_state", 32'(fsm_state), 32'(S_IDLE));
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_rem", 32'(ships_remaining), 32'd0);
    chk("rst_fin", 32'(finished_placing), 32'd0);
    chk_cursor("rst_cur", 0, 0);
    step();

    // Two-ship session
    rst = 1'b1; enable = 1'b1; ships_count = 3'd2;
    step();
    chk("load_state", 32'(fsm_state), 32'(S_LOAD));
    step();
    chk("move_state", 32'(fsm_state), 32'(S_MOVE));
    chk("load_rem", 32'(ships_remaining), 32'd2);
    chk("load_occ", 32'(occupancy), 32'd0);
    chk_cursor("load_cur", 0, 0);

    press(B_RT); press(B_RT); press(B_RT); press(B_DN);
    chk_cursor("walk", 3, 1);
    set_btn(B_CF);
    step();
    chk("p1_ok", 32'(place_ok), 32'd1);
    chk("p1_err", 32'(place_err), 32'd0);
    chk("p1_occ", 32'(occupancy), 32'h100);
    chk("p1_rem", 32'(ships_remaining), 32'd1);
    chk_cursor("p1_cur", 0, 0);
    set_btn(5'b0);
    step();
    chk("p1_ok_drop", 32'(place_ok), 32'd0);

    set_btn(B_CF);
    step();
    chk("p2_ok", 32'(place_ok), 32'd1);
    chk("p2_occ", 32'(occupancy), 32'h101);
    chk("p2_rem", 32'(ships_remaining), 32'd0);
    chk("p2_state", 32'(fsm_state), 32'(S_DONE));
    chk("p2_fin", 32'(finished_placing), 32'd1);
    set_btn(5'b0);
    step();
    chk("done_ok_drop", 32'(place_ok), 32'd0);
    chk("done_fin", 32'(finished_placing), 32'd1);
    press(B_RT);
    press(B_CF);
    chk("done_ignore_occ", 32'(occupancy), 32'h101);
    chk_cursor("done_ignore_cur", 0, 0);

    enable = 1'b0;
    step();
    chk("leave_state", 32'(fsm_state), 32'(S_IDLE));
    chk("leave_fin", 32'(finished_placing), 32'd0);
    chk("leave_occ_kept", 32'(occupancy), 32'h101);

    // Three-ship session; restart passes through LOAD
    ships_count = 3'd3; enable = 1'b1;
    step(); step();
    chk("s3_rem", 32'(ships_remaining), 32'd3);
    chk("s3_occ", 32'(occupancy), 32'd0);
    press(B_CF);
    chk("s3_p1_occ", 32'(occupancy), 32'h1);
    chk("s3_p1_rem", 32'(ships_remaining), 32'd2);
    set_btn(B_CF);
    step();
    chk("err_pulse", 32'(place_err), 32'd1);
    chk("err_ok", 32'(place_ok), 32'd0);
    chk("err_rem", 32'(ships_remaining), 32'd2);
    chk("err_occ", 32'(occupancy), 32'h1);
    set_btn(5'b0);
    step();
    chk("err_drop", 32'(place_err), 32'd0);

    press(B_RT); press(B_RT); press(B_DN); press(B_DN);
    chk_cursor("to22", 2, 2);
    press(B_UP | B_RT);
    chk_cursor("up_rt", 2, 1);

    set_btn(B_RT);
    step(); step(); step();
    chk_cursor("hold_rt", 3, 1);
    set_btn(5'b0);
    step();
    press(B_LT);
    chk_cursor("back_lt", 2, 1);

    set_btn(B_CF | B_RT);
    step();
    chk("cfrt_ok", 32'(place_ok), 32'd1);
    chk("cfrt_occ", 32'(occupancy), 32'h81);
    chk("cfrt_rem", 32'(ships_remaining), 32'd1);
    chk_cursor("cfrt_cur", 0, 0);
    set_btn(5'b0);
    step();

    press(B_LT);
`ifdef PLACE_WRAP_EN
    chk_cursor("left_edge", 4, 0);
`else
    chk_cursor("left_edge", 0, 0);
`endif
    press(B_UP);
`ifdef PLACE_WRAP_EN
    chk_cursor("up_edge", 4, 4);
`else
    chk_cursor("up_edge", 0, 0);
`endif

    // Dropping enable beats a same-cycle confirm
    enable = 1'b0;
    set_btn(B_CF);
    step();
    chk("en_beats_state", 32'(fsm_state), 32'(S_IDLE));
    chk("en_beats_ok", 32'(place_ok), 32'd0);
    chk("en_beats_err", 32'(place_err), 32'd0);
    chk("en_beats_occ", 32'(occupancy), 32'h81);
    chk("en_beats_rem", 32'(ships_remaining), 32'd1);
    set_btn(5'b0);
    step();

    // Asynchronous reset mid-placement
    enable = 1'b1;
    step(); step();
    press(B_DN);
    press(B_CF);
    chk("pre_rst_occ", 32'(occupancy), 32'h20);
    ships_count = 3'd0;
    rst = 1'b0;
    #2;
    chk("arst_state", 32'(fsm_state), 32'(S_IDLE));
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_rem", 32'(ships_remaining), 32'd0);
    chk_cursor("arst_cur", 0, 0);
    rst = 1'b1;
    step(); step();
    chk("clamp0_rem", 32'(ships_remaining), 32'd1);

    enable = 1'b0;
    step();
    ships_count = 3'd7; enable = 1'b1;
    step(); step();
    chk("clamp7_rem", 32'(ships_remaining), 32'd5);
    chk("clamp7_state", 32'(fsm_state), 32'(S_MOVE));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
